// File: rtl/affine_interp_fir_acc_if.sv
// Streaming bundle between the MCM product banks, the interpolation FIR and the
// prediction buffer: eight signed tap products in, one clipped pixel out.
interface affine_interp_fir_acc_if #(
    parameter int PW    = 16,
    parameter int OUT_W = 8
);
    logic                    in_valid;
    logic                    in_ready;
    logic signed [PW-1:0]    p1;
    logic signed [PW-1:0]    p2;
    logic signed [PW-1:0]    p3;
    logic signed [PW-1:0]    p4;
    logic signed [PW-1:0]    p5;
    logic signed [PW-1:0]    p6;
    logic signed [PW-1:0]    p7;
    logic signed [PW-1:0]    p8;
    logic                    out_valid;
    logic                    out_ready;
    logic [OUT_W-1:0]        out_sample;
    logic                    out_last;

    modport master (
        output in_valid, p1, p2, p3, p4, p5, p6, p7, p8, out_ready,
        input  in_ready, out_valid, out_sample, out_last
    );

    modport slave (
        input  in_valid, p1, p2, p3, p4, p5, p6, p7, p8, out_ready,
        output in_ready, out_valid, out_sample, out_last
    );
endinterface

// File: rtl/affine_interp_fir_acc.sv
// Transposed-form 8-tap accumulator for affine interpolation: sums per-tap MCM
// products over a row, then rounds, shifts and clips each result to a pixel.
module affine_interp_fir_acc #(
    parameter int PW    = 16,
    parameter int ACC_W = 20,
    parameter int SHIFT = 6,
    parameter int OUT_W = 8,
    parameter int LEN_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     row_len,
    output logic                 busy,
    affine_interp_fir_acc_if.slave io
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic signed [ACC_W:0] ROUND   = (ACC_W+1)'(1 << (SHIFT-1));
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << OUT_W) - 1);
    localparam logic [LEN_W-1:0]      MIN_LEN = LEN_W'(8);
    localparam logic [LEN_W-1:0]      FILL_LAST = LEN_W'(6);

    state_t                  state_reg;
    logic [LEN_W-1:0]        cnt_reg;
    logic [LEN_W-1:0]        len_reg;
    logic                    out_valid_reg;
    logic                    out_last_reg;
    logic [OUT_W-1:0]        out_sample_reg;

    logic signed [PW-1:0]    prod_in  [1:8];
    logic signed [ACC_W-1:0] prod_ext [1:8];
    logic signed [ACC_W-1:0] chain_reg [1:7];

    logic                    start_ok;
    logic                    in_ready_int;
    logic                    accept;
    logic                    is_last;
    logic signed [ACC_W:0]   sum_full;
    logic signed [ACC_W:0]   rounded;
    logic [OUT_W-1:0]        pix_next;

    assign prod_in[1] = io.p1;
    assign prod_in[2] = io.p2;
    assign prod_in[3] = io.p3;
    assign prod_in[4] = io.p4;
    assign prod_in[5] = io.p5;
    assign prod_in[6] = io.p6;
    assign prod_in[7] = io.p7;
    assign prod_in[8] = io.p8;

    genvar gi;
    generate
        for (gi = 1; gi <= 8; gi++) begin : g_ext
            assign prod_ext[gi] = {{(ACC_W-PW){prod_in[gi][PW-1]}}, prod_in[gi]};
        end
    endgenerate

    assign start_ok     = start && (state_reg == IDLE) && (row_len >= MIN_LEN);
    // Single output register: stall input whenever a pending pixel cannot leave.
    assign in_ready_int = ((state_reg == FILL) || (state_reg == RUN)) &&
                          (!out_valid_reg || io.out_ready);
    assign accept       = io.in_valid && in_ready_int;
    assign is_last      = (cnt_reg == (len_reg - LEN_W'(1)));

    // Oldest products enter at R7 and ripple toward R1 gathering newer taps.
    generate
        for (gi = 1; gi <= 7; gi++) begin : g_chain
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg[gi] <= '0;
                end else if (start_ok) begin
                    chain_reg[gi] <= '0;
                end else if (accept) begin
                    if (gi == 7) begin : g_tail
                        chain_reg[gi] <= prod_ext[8];
                    end else begin : g_mid
                        chain_reg[gi] <= chain_reg[gi+1] + prod_ext[gi+1];
                    end
                end
            end
        end
    endgenerate

    always_comb begin
        sum_full = {chain_reg[1][ACC_W-1], chain_reg[1]} +
                   {prod_ext[1][ACC_W-1], prod_ext[1]};
        rounded  = (sum_full + ROUND) >>> SHIFT;
        pix_next = '0;
        if (rounded < 0) begin
            pix_next = '0;
        end else if (rounded > PIX_MAX) begin
            pix_next = '1;
        end else begin
            pix_next = rounded[OUT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            len_reg        <= '0;
            out_valid_reg  <= 1'b0;
            out_last_reg   <= 1'b0;
            out_sample_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start_ok) begin
                        state_reg <= FILL;
                        cnt_reg   <= '0;
                        len_reg   <= row_len;
                    end
                end
                FILL: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + LEN_W'(1);
                        if (cnt_reg == FILL_LAST) begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt_reg <= cnt_reg + LEN_W'(1);
                        if (is_last) begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase

            if (accept && (state_reg == RUN)) begin
                out_valid_reg  <= 1'b1;
                out_last_reg   <= is_last;
                out_sample_reg <= pix_next;
            end else if (out_valid_reg && io.out_ready) begin
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
            end
        end
    end

    assign io.in_ready   = in_ready_int;
    assign io.out_valid  = out_valid_reg;
    assign io.out_last   = out_last_reg;
    assign io.out_sample = out_sample_reg;
    assign busy          = (state_reg != IDLE);

endmodule

// File: doc/affine_interp_fir_acc.md
Name: affine_interp_fir_acc

Overview:
- Sequential consumer of the affine interpolation MCM product banks.
- Each accepted cycle it takes the eight per-tap products of one reference sample and accumulates them in a transposed-form 8-tap delay chain.
- It rounds, shifts and clips the sum to an 8-bit interpolated pixel.
- Operates row by row, with valid/ready handshakes on both sides, between the MCM stage and the prediction buffer.

Parameters:
- PW, 16, width of each signed input product.
- ACC_W, 20, width of the signed chain/accumulator registers (at least PW+3).
- SHIFT, 6, normalisation right-shift.
- OUT_W, 8, output sample width (unsigned).
- LEN_W, 8, width of the row length field.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a row; honoured only in IDLE.
- row_len  input  LEN_W  input samples in the row, including 7 leading pad samples; sampled on start.
- in_valid  input  1  P1..P8 valid.
- in_ready  output  1  block accepts products this cycle.
- P1..P8  input  PW each  signed products of the current sample by taps 1..8; tap 1 applies to the newest sample.
- out_valid  output  1  out_sample valid.
- out_ready  input  1  downstream accepts.
- out_sample  output  OUT_W  clipped interpolated pixel.
- out_last  output  1  qualifies the final output of the row.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (async, rst_n=0): state IDLE, chain R1..R7=0, sample counter=0, in_ready=0, out_valid=0, out_sample=0, out_last=0, busy=0.
- States:
  - IDLE -> FILL on start when row_len>=8. start with row_len<8 is ignored and the block stays IDLE.
  - FILL: the first 7 accepts produce no output. FILL -> RUN on the 7th accept.
  - RUN: each accept produces one output. RUN -> IDLE on the accept of sample row_len-1.
- Entering FILL clears R1..R7 and the counter, so there is no leakage between rows. start outside IDLE is ignored.
- Accept = in_valid && in_ready.
- in_ready = (state is FILL or RUN) && (!out_valid || out_ready). Single output register, no skid buffer.
- Chain update on accept (sign-extend all products to ACC_W):
  - R7 <= P8.
  - Rk <= R(k+1) + P(k+1) for k=1..6.
  - sum = R1 + P1, combinational.
  - Net result: y[n] = sum over k of Pk(x[n-k+1]).
- No accept: the chain holds.
- Output on an accept in RUN, registered one cycle after accept:
  - out_sample <= clip((sum + 2^(SHIFT-1)) >>> SHIFT, 0, 2^OUT_W-1).
  - The shift is arithmetic.
  - out_valid <= 1.
  - out_last <= 1 if this is sample row_len-1, else 0.
- out_valid && out_ready with no new output that cycle: out_valid <= 0 and out_last <= 0. out_sample holds.
- out_valid && !out_ready: out_sample and out_last hold stable, and in_ready=0.
- Outputs per row = row_len-7.
- A new start is legal in the cycle after the last accept. The last output may still be pending; in_ready stays low until it drains.
- Latency: 1 cycle from the accept of sample 7+j to output j.
- The counter is LEN_W bits and does not wrap, since row_len <= 2^LEN_W-1.

Test Plan:
- All P=800 every cycle, row_len=16 -> 9 outputs of 100, out_last only on the 9th; no output during the first 7 accepts.
- Impulse: P=0 except sample index 7, where Pk=64*k, row_len=16 -> outputs 1,2,3,4,5,6,7,8,0.
- Clip: all P=-100 -> sum -800 -> 0; all P=3000 -> sum 24000 -> 255. Rounding: all P=4 (sum 32) -> 1; all P=3 (sum 24) -> 0.
- Backpressure: all P=800, out_ready low for 5 cycles after the first output -> out_sample=100 held, in_ready=0, no product lost. Total output count is still row_len-7, with no duplicates.
- Random in_valid gaps with a random out_ready pattern against a reference model -> exact output match and a correct out_last position.
- Control corner cases:
  - start with row_len=5 -> stays IDLE, busy=0.
  - start during RUN -> ignored.
  - rst_n pulsed low mid-row -> all outputs 0 immediately; the next row is unaffected by prior chain contents.
